// File: rtl/cpu_fetch.sv
// -----------------------------------------------------------------------------
// cpu_fetch -- instruction byte prefetcher with a small FIFO queue.
//
// Purpose:
//   Reads consecutive bytes from a simple system bus. Each read takes TCYCLES
//   clocks. Fetched {pc, byte} pairs are pushed into a DEPTH-entry queue that a
//   decoder drains. A redirect flushes the queue, drops any read in flight and
//   restarts fetching at a new PC.
//
// Parameters:
//   ADDR_WIDTH  bus / PC address width
//   DATA_WIDTH  fetched byte width
//   DEPTH       prefetch queue entries (>= 1)
//   TCYCLES     clocks per memory access (>= 1)
//   RESET_PC    first fetch address after reset
//
// Ports:
//   clk              single clock, rising edge
//   reset_n          asynchronous active-low reset
//   mem_addr         bus address; always equals the current fetch PC
//   mem_read_enable  bus read strobe; high exactly while an access is running
//   mem_data_in      bus read data, sampled on the last T-cycle of an access
//   instr_valid      queue head valid (queue not empty)
//   instr_data       queue head byte
//   instr_pc         address of the queue head byte
//   instr_ready      consumer accepts the head byte
//   redirect_valid   flush the queue and restart fetching at redirect_addr
//   redirect_addr    new fetch PC
//   fetch_count      (CPU_FETCH_PERF_EN only) completed pushes, wrapping
//   flush_count      (CPU_FETCH_PERF_EN only) redirects taken, wrapping
//
// Handshake: a byte leaves the queue on a rising edge where instr_valid and
// instr_ready are both high; instr_valid never depends on instr_ready, and
// instr_data/instr_pc are stable while instr_valid is high and not popped.
//
// Optional feature: define CPU_FETCH_PERF_EN to add the two perf counters.
// -----------------------------------------------------------------------------
module cpu_fetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 2,
    parameter int                    TCYCLES    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           flush_count
`endif
);

    localparam int TW = (TCYCLES > 1) ? $clog2(TCYCLES) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [TW-1:0] TCNT_LAST = TW'(TCYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;

    logic                  state_q,    state_d;
    logic [TW-1:0]         tcnt_q,     tcnt_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         count_q,    count_d;
    logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;

    // Queue storage: contents need no reset, validity is tracked by count_q.
    logic [DATA_WIDTH-1:0] qdata_q [DEPTH];
    logic [ADDR_WIDTH-1:0] qpc_q   [DEPTH];

    logic          do_pop;
    logic          do_complete;
    logic          do_push;
    logic [CW-1:0] count_after_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign do_pop      = (count_q != '0) && instr_ready;
    assign do_complete = (state_q == ST_ACCESS) && (tcnt_q == TCNT_LAST);
    // A completion on a redirect edge is dropped: the byte belongs to the
    // abandoned path.
    assign do_push     = do_complete && !redirect_valid;

    // Occupancy seen by the start/continue decision: this edge's pop counts.
    assign count_after_pop = count_q - CW'(do_pop);

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_valid) begin
            state_d    = ST_ACCESS;
            tcnt_d     = '0;
            fetch_pc_d = redirect_addr;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d   = ptr_inc(wr_ptr_q);
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
            end
            count_d = count_after_pop + CW'(do_push);

            case (state_q)
                ST_IDLE: begin
                    if (count_after_pop < DEPTH_C) begin
                        state_d = ST_ACCESS;
                        tcnt_d  = '0;
                    end
                end
                default: begin
                    if (!do_complete) begin
                        tcnt_d = tcnt_q + TW'(1);
                    end else begin
                        // Only start another read if its result has a slot.
                        tcnt_d  = '0;
                        state_d = (count_d < DEPTH_C) ? ST_ACCESS : ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            qdata_q[wr_ptr_q] <= mem_data_in;
            qpc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign mem_addr        = fetch_pc_q;
    assign mem_read_enable = (state_q == ST_ACCESS);
    assign instr_valid     = (count_q != '0);
    assign instr_data      = qdata_q[rd_ptr_q];
    assign instr_pc        = qpc_q[rd_ptr_q];

`ifdef CPU_FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(do_push);
        flush_count_d = flush_count_q + 32'(redirect_valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// -----------------------------------------------------------------------------
// tb_cpu_fetch -- self-checking bench for cpu_fetch.
//
// Two instances share clock and reset: u_dut with default parameters and
// u_fast with TCYCLES=1, DEPTH=4. The memory model returns
// addr[7:0] ^ addr[15:8], which equals addr[7:0] for addresses below 0x0100.
// Inputs are driven 1 time unit after a rising edge; outputs are checked at
// that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_cpu_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    logic [15:0] mem_addr;
    logic        mem_read_enable;
    logic [7:0]  mem_data_in;
    logic        instr_valid;
    logic [7:0]  instr_data;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_addr;

    logic [15:0] f_mem_addr;
    logic        f_mem_read_enable;
    logic [7:0]  f_mem_data_in;
    logic        f_instr_valid;
    logic [7:0]  f_instr_data;
    logic [15:0] f_instr_pc;
    logic        f_instr_ready;
    logic        f_redirect_valid;
    logic [15:0] f_redirect_addr;

`ifdef CPU_FETCH_PERF_EN
    logic [31:0] fetch_count, flush_count;
    logic [31:0] f_fetch_count, f_flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q[$];

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    assign mem_data_in   = mem_fn(mem_addr);
    assign f_mem_data_in = mem_fn(f_mem_addr);

    cpu_fetch u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_addr        (mem_addr),
        .mem_read_enable (mem_read_enable),
        .mem_data_in     (mem_data_in),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr)
`ifdef CPU_FETCH_PERF_EN
        ,
        .fetch_count     (fetch_count),
        .flush_count     (flush_count)
`endif
    );

    cpu_fetch #(.TCYCLES(1), .DEPTH(4)) u_fast (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_addr        (f_mem_addr),
        .mem_read_enable (f_mem_read_enable),
        .mem_data_in     (f_mem_data_in),
        .instr_valid     (f_instr_valid),
        .instr_data      (f_instr_data),
        .instr_pc        (f_instr_pc),
        .instr_ready     (f_instr_ready),
        .redirect_valid  (f_redirect_valid),
        .redirect_addr   (f_redirect_addr)
`ifdef CPU_FETCH_PERF_EN
        ,
        .fetch_count     (f_fetch_count),
        .flush_count     (f_flush_count)
`endif
    );

    // ---------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_ready      = 1'b0;
        redirect_valid   = 1'b0;
        redirect_addr    = 16'h0000;
        f_instr_ready    = 1'b0;
        f_redirect_valid = 1'b0;
        f_redirect_addr  = 16'h0000;
    endtask

    // Returns just after reset release; the next step() lands after edge 1.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (mem_read_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en got=%b exp=0", mem_read_enable);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", instr_valid);
        end
        checks++;
        if (mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (mem_read_enable !== 1'b1 || mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL first_edge_access got rd=%b addr=%h exp rd=1 addr=0000",
                     mem_read_enable, mem_addr);
        end
    endtask

    task automatic test_first_fetch();
        logic exp_v;
        logic [15:0] exp_pc;
        do_reset();
        instr_ready = 1'b1;
        step();
        for (int e = 2; e <= 9; e++) begin
            step();
            exp_v  = (e == 5) || (e == 9);
            exp_pc = (e == 5) ? 16'h0000 : 16'h0001;
            checks++;
            if (instr_valid !== exp_v) begin
                failures++;
                $display("FAIL first_fetch_valid edge=%0d got=%b exp=%b", e, instr_valid, exp_v);
            end else if (exp_v) begin
                checks++;
                if (instr_pc !== exp_pc || instr_data !== exp_pc[7:0]) begin
                    failures++;
                    $display("FAIL first_fetch_byte edge=%0d got pc=%h data=%h exp pc=%h data=%h",
                             e, instr_pc, instr_data, exp_pc, exp_pc[7:0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (20) step();
        checks++;
        if (mem_read_enable !== 1'b0) begin
            failures++;
            $display("FAIL full_idle_rd_en got=%b exp=0", mem_read_enable);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 8'h00) begin
            failures++;
            $display("FAIL full_head got v=%b pc=%h data=%h exp v=1 pc=0000 data=00",
                     instr_valid, instr_pc, instr_data);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0001 || instr_data !== 8'h01) begin
            failures++;
            $display("FAIL after_pop_head got v=%b pc=%h data=%h exp v=1 pc=0001 data=01",
                     instr_valid, instr_pc, instr_data);
        end
        checks++;
        if (mem_read_enable !== 1'b1 || mem_addr !== 16'h0002) begin
            failures++;
            $display("FAIL after_pop_access got rd=%b addr=%h exp rd=1 addr=0002",
                     mem_read_enable, mem_addr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (7) step();   // one byte queued, second access at tcnt=2
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0150;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== 16'h0150 || mem_read_enable !== 1'b1) begin
            failures++;
            $display("FAIL redirect_flush got v=%b addr=%h rd=%b exp v=0 addr=0150 rd=1",
                     instr_valid, mem_addr, mem_read_enable);
        end
        instr_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_early_valid got=%b exp=0", instr_valid);
        end
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0150 || instr_data !== 8'h51) begin
            failures++;
            $display("FAIL redirect_first_byte got v=%b pc=%h data=%h exp v=1 pc=0150 data=51",
                     instr_valid, instr_pc, instr_data);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] got_pc[2];
        logic [7:0]  got_data[2];
        int n = 0;
        do_reset();
        instr_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            if (instr_valid === 1'b1) begin
                got_pc[n]   = instr_pc;
                got_data[n] = instr_data;
                n++;
            end
            step();
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL wrap_timeout got=%0d bytes exp=2", n);
        end else begin
            checks++;
            if (got_pc[0] !== 16'hFFFF || got_data[0] !== 8'h00) begin
                failures++;
                $display("FAIL wrap_byte0 got pc=%h data=%h exp pc=ffff data=00",
                         got_pc[0], got_data[0]);
            end
            checks++;
            if (got_pc[1] !== 16'h0000 || got_data[1] !== 8'h00) begin
                failures++;
                $display("FAIL wrap_byte1 got pc=%h data=%h exp pc=0000 data=00",
                         got_pc[1], got_data[1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0150;
        step();
        redirect_valid = 1'b0;
        step();              // access to 0x0150 now at tcnt=1
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_read_enable !== 1'b0 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_abort got rd=%b addr=%h v=%b exp rd=0 addr=0000 v=0",
                     mem_read_enable, mem_addr, instr_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (mem_read_enable !== 1'b1 || mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL abort_restart got rd=%b addr=%h exp rd=1 addr=0000",
                     mem_read_enable, mem_addr);
        end
        instr_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 8'h00) begin
            failures++;
            $display("FAIL abort_first_byte got v=%b pc=%h data=%h exp v=1 pc=0000 data=00",
                     instr_valid, instr_pc, instr_data);
        end
    endtask

    // Random consumer stalls and redirects; the model only knows that bytes
    // arrive in address order from the last redirect target (or RESET_PC).
    task automatic test_random();
        logic [15:0] stream_pc = 16'h0000;
        logic [23:0] e;
        logic        redir_prev = 1'b0;
        logic [15:0] redir_addr_prev = 16'h0000;
        int          pops = 0;
        do_reset();
        exp_q.delete();
        step();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (redir_prev) begin
                checks++;
                if (instr_valid !== 1'b0 || mem_addr !== redir_addr_prev || mem_read_enable !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_redirect cyc=%0d got v=%b addr=%h rd=%b exp v=0 addr=%h rd=1",
                             cyc, instr_valid, mem_addr, mem_read_enable, redir_addr_prev);
                end
            end
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_addr  = 16'($urandom);
            instr_ready    = ($urandom_range(0, 99) < 60);
            if (redirect_valid) begin
                exp_q.delete();
                stream_pc = redirect_addr;
            end else if (instr_valid === 1'b1 && instr_ready) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back({stream_pc, mem_fn(stream_pc)});
                    stream_pc = stream_pc + 16'h0001;
                end
                e = exp_q.pop_front();
                pops++;
                checks++;
                if ({instr_pc, instr_data} !== e) begin
                    failures++;
                    $display("FAIL rand_pop cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                             cyc, instr_pc, instr_data, e[23:8], e[7:0]);
                end
            end
            redir_prev      = redirect_valid;
            redir_addr_prev = redirect_addr;
            step();
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        checks++;
        if (pops < 100) begin
            failures++;
            $display("FAIL rand_progress got=%0d pops exp>=100", pops);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        f_instr_ready = 1'b1;
        step();              // edge 1: access starts
        step();              // edge 2: first byte queued
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (f_instr_valid !== 1'b1 || f_instr_pc !== 16'(k) || f_instr_data !== 8'(k)) begin
                failures++;
                $display("FAIL b2b_byte k=%0d got v=%b pc=%h data=%h exp v=1 pc=%h data=%h",
                         k, f_instr_valid, f_instr_pc, f_instr_data, 16'(k), 8'(k));
            end
`ifdef CPU_FETCH_PERF_EN
            if (k == 9) begin
                checks++;
                if (f_fetch_count !== 32'd10 || f_flush_count !== 32'd0) begin
                    failures++;
                    $display("FAIL perf_counts got fetch=%0d flush=%0d exp fetch=10 flush=0",
                             f_fetch_count, f_flush_count);
                end
            end
`endif
            step();
        end
        f_instr_ready = 1'b0;
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning bus/PC address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning fetched byte width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning prefetch queue entries (legal >=1).
REQ-004 SHALL have parameter TCYCLES, default 4, meaning clocks per memory access (legal >=1).
REQ-005 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port mem_addr, output, ADDR_WIDTH, system bus address.
REQ-009 SHALL have port mem_read_enable, output, 1, system bus read strobe.
REQ-010 SHALL have port mem_data_in, input, DATA_WIDTH, system bus read data.
REQ-011 SHALL have ports instr_valid (output, 1), instr_data (output, DATA_WIDTH) and instr_pc (output, ADDR_WIDTH), the queue-head byte and its address.
REQ-012 SHALL have port instr_ready, input, 1, consumer pop; a pop occurs when instr_valid and instr_ready are both high.
REQ-013 SHALL have ports redirect_valid (input, 1) and redirect_addr (input, ADDR_WIDTH), flush and restart fetch at a new PC.

Function
REQ-014 SHALL implement states IDLE and ACCESS, with T-cycle counter tcnt counting 0..TCYCLES-1 in ACCESS.
REQ-015 In IDLE, with queue count < DEPTH after this edge's pop, SHALL enter ACCESS with tcnt=0; otherwise stays IDLE.
REQ-016 In ACCESS with tcnt<TCYCLES-1, SHALL increment tcnt.
REQ-017 In ACCESS with tcnt=TCYCLES-1, SHALL sample mem_data_in, push {fetch_pc, data} to the queue tail and increment fetch_pc modulo 2^ADDR_WIDTH.
REQ-018 On that completion edge SHALL re-enter ACCESS (tcnt=0) if post-push/post-pop count < DEPTH, else go to IDLE.
REQ-019 SHALL hold mem_read_enable high exactly while state is ACCESS and mem_addr equal to fetch_pc at all times.
REQ-020 SHALL keep at most one access in flight; push never overflows because an access starts only with a free slot.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 instr_valid SHALL be high iff count>0; instr_data and instr_pc are don't-care when it is low.
REQ-023 redirect_valid SHALL take priority over push and pop; on that edge: queue emptied, any in-flight access aborted without a push, fetch_pc<=redirect_addr, state<=ACCESS with tcnt=0.
REQ-024 A redirect on the same edge as an access completion SHALL discard the completing byte.
REQ-025 fetch_pc at all-ones SHALL wrap to 0 after its fetch completes.

Reset
REQ-026 While reset_n is low: state=IDLE, tcnt=0, count=0, fetch_pc=RESET_PC, mem_read_enable=0, instr_valid=0, mem_addr=RESET_PC.
REQ-027 Asserting reset_n low mid-access SHALL abort it immediately, with no push.
REQ-028 The first edge after reset_n rises SHALL enter ACCESS (queue empty).

Configuration
REQ-029 With macro CPU_FETCH_PERF_EN defined, SHALL add outputs fetch_count (32, +1 per completed push) and flush_count (32, +1 per redirect), both wrapping and reset to 0.
REQ-030 Without CPU_FETCH_PERF_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Defaults, memory returns addr[7:0], instr_ready=1: edge 1 after reset releases -> mem_read_enable=1, mem_addr=0; after edge 5 -> instr_valid=1, instr_data=0x00, instr_pc=0x0000; the next byte 0x01 follows 4 edges later.
REQ-032 instr_ready=0 throughout: exactly 2 pushes (pc 0,1), then IDLE with mem_read_enable=0; raising instr_ready for one cycle -> one pop, new access at mem_addr=0x0002.
REQ-033 redirect_valid with redirect_addr=0x0150 at tcnt=2 with 1 entry queued -> next cycle instr_valid=0, mem_addr=0x0150, tcnt=0; the first byte delivered has instr_pc=0x0150.
REQ-034 Redirect to 0xFFFF, consumer ready -> bytes delivered with instr_pc 0xFFFF, then 0x0000.
REQ-035 reset_n pulsed low at tcnt=1 -> mem_read_enable drops asynchronously, queue empty, fetch restarts at RESET_PC.
REQ-036 TCYCLES=1, DEPTH=4, CPU_FETCH_PERF_EN defined, consumer ready -> one byte per clock sustained; fetch_count=10 after 10 deliveries.
